// File: rtl/serial_to_parallel.sv
//------------------------------------------------------------------------------
// Module   : serial_to_parallel
// Brief    : Deserializer assembling WIDTH-bit words from a qualified serial bit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_to_parallel #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             d_valid,
  input  logic             d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_sr_next;
  logic             w_last;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sr_next = {r_sr[WIDTH-2:0], d};
    end else begin : g_lsb_first
      assign w_sr_next = {d, r_sr[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == c_last_cnt);

  // The completed word goes straight from the shift value into q, so q never
  // carries a partial word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sr      <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
    end else if (clr) begin
      r_state   <= IDLE;
      r_q_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
    end else if (d_valid) begin
      r_sr <= w_sr_next;
      if (w_last) begin
        r_q       <= w_sr_next;
        r_q_valid <= 1'b1;
        r_state   <= IDLE;
        r_busy    <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_q_valid <= 1'b0;
        r_state   <= RECV;
        r_busy    <= 1'b1;
        r_cnt     <= r_cnt + c_cnt_one;
      end
    end else begin
      r_q_valid <= 1'b0;
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign busy    = r_busy;
  assign bit_cnt = r_cnt;

endmodule

`default_nettype wire

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
Deserializer that consumes a latched serial data line, one bit per qualified clock edge, and assembles WIDTH-bit words. Sits directly downstream of the level-sensitive storage element that holds the serial bit (d). Presents each completed word on a held parallel output with a one-cycle valid strobe. Intended as the capture front-end for the chapter's register and counter exercises.

Parameters:
WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
MSB_FIRST, 1, 1 means the first received bit lands in q[WIDTH-1]; 0 means it lands in q[0].
CNT_W, $clog2(WIDTH), width of the bit counter; derived, never overridden.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  synchronous reset, active-low.
clr  input  1  synchronous abort of the partial word.
d_valid  input  1  qualifies d; a bit is sampled only when this is high.
d  input  1  serial data bit.
q  output  WIDTH  last completed word; held until the next word completes.
q_valid  output  1  one-cycle strobe marking a new word on q.
busy  output  1  high while a partial word is in progress.
bit_cnt  output  CNT_W  number of bits received in the current word.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (rst_n).
- Priority at each rising edge: rst_n low, then clr, then d_valid, then hold.
- Reset (rst_n=0 at an edge): internal shift register sr, q, q_valid, busy and bit_cnt all go to 0. This applies mid-word too; a partial word is lost.
- FSM states:
  - IDLE: bit_cnt=0, busy=0.
  - RECV: 0 < bit_cnt <= WIDTH-1, busy=1.
  - busy is a registered copy of (state==RECV).
- Shift rule, on d_valid=1 (no clr):
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], d}.
  - MSB_FIRST=0: sr <= {d, sr[WIDTH-1:1]}.
- Counting, on d_valid=1:
  - If bit_cnt < WIDTH-1: bit_cnt increments; IDLE goes to RECV.
  - If bit_cnt == WIDTH-1 (final bit):
    - q <= the completed word, including the current d, shifted per the rule above.
    - q_valid <= 1.
    - bit_cnt wraps to 0; go to IDLE; busy <= 0.
- Latency: q and q_valid update on the same edge that samples the final bit, and are visible in the following cycle.
- q_valid is high for exactly one cycle. Back-to-back words with d_valid held high are allowed; this gives pulses exactly WIDTH cycles apart with no bit lost.
- d_valid=0: sr, bit_cnt and state hold; q_valid <= 0. Gaps of any length between bits are legal.
- clr=1 (rst_n=1): bit_cnt <= 0, go to IDLE, busy <= 0, q_valid <= 0. q keeps its previous word.
  - clr together with d_valid: clr wins and the bit is dropped.
  - clr on the final-bit cycle: the word is discarded and no q_valid is produced.
- sr contents outside a word are don't-care. q must never show a partial word.
- No overflow condition exists; the counter wraps only on word completion.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, d_valid=1 for 8 cycles, d=1,0,1,1,0,0,1,0 -> q=8'hB2 with q_valid high for 1 cycle; bit_cnt steps 1..7 then 0; busy high for 7 cycles.
2. MSB_FIRST=0, same bit stream -> q=8'h4D, q_valid single pulse.
3. MSB_FIRST=1, same bits as scenario 1 but d_valid low for 3 cycles between bits 2/3 and 5/6 -> q=8'hB2; bit_cnt holds during gaps; no early q_valid.
4. Back-to-back words 8'hA5 then 8'h3C (MSB first), d_valid continuous for 16 cycles -> q_valid pulses 8 cycles apart; q=8'hA5 then 8'h3C.
5. After q=8'hA5, send 3 bits then clr=1 (with d_valid=1) -> bit_cnt=0, busy=0, q stays 8'hA5, no q_valid; a following 8'h3C word is captured correctly.
6. rst_n=0 for 1 cycle after 5 bits of a word -> q, q_valid, busy, bit_cnt all 0 at the next edge; a following 8-bit word 8'hFF gives q=8'hFF.
